// File: rtl/mm_pkg.sv
// Shared constants, FSM state type and tag helper for the main-memory requester.
package mm_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 2;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_LOAD,
        RD_CAPT,
        DONE
    } mm_req_state_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

endpackage

// File: rtl/mm_requester.sv
// Single-outstanding initiator for one port of the shared main memory.
// Optional read-wait timeout enabled by defining MM_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | ready for a core request, memory port quiet
//   WR      | one-cycle write strobe with latched address/data
//   RD_REQ  | read strobe held until the memory reports valid
//   RD_LOAD | address held while the memory loads its read data
//   RD_CAPT | capture memory data and tag into the response
//   DONE    | one-cycle response pulse
module mm_requester
    import mm_pkg::*;
#(
`ifdef MM_TIMEOUT_EN
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_err,
    output logic              mm_read,
    output logic              mm_write,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic              mm_valid,
    input  logic [DATA_W-1:0] mm_rdata,
    input  logic [TAG_W-1:0]  mm_tag
);

    mm_req_state_t     r_state;
    mm_req_state_t     w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [TAG_W-1:0]  r_resp_tag;
    logic              w_timeout;

`ifdef MM_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic [3:0] r_wait_cnt;
    logic       r_resp_err;

    assign w_timeout = (r_state == RD_REQ) && !mm_valid && (r_wait_cnt == WAIT_LAST);
    assign resp_err  = r_resp_err;

    // Counter is zero on every RD_REQ entry because it clears outside RD_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == RD_REQ) ? r_wait_cnt + 4'd1 : 4'd0;
            if (w_timeout)
                r_resp_err <= 1'b1;
            else if (r_state == WR || r_state == RD_CAPT)
                r_resp_err <= 1'b0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign resp_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = req_we ? WR : RD_REQ;
            WR:      w_next_state = DONE;
            RD_REQ:  if (mm_valid) w_next_state = RD_LOAD;
                     else if (w_timeout) w_next_state = DONE;
            RD_LOAD: w_next_state = RD_CAPT;
            RD_CAPT: w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mm_read    = 1'b0;
        mm_write   = 1'b0;
        mm_addr    = '0;
        mm_wdata   = '0;
        case (r_state)
            IDLE:    req_ready = 1'b1;
            WR: begin
                mm_write = 1'b1;
                mm_addr  = r_addr;
                mm_wdata = r_wdata;
            end
            RD_REQ: begin
                mm_read = 1'b1;
                mm_addr = r_addr;
            end
            RD_LOAD: mm_addr = r_addr;
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_resp_tag   <= '0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == WR || w_timeout)
                r_resp_tag <= tag_of(r_addr);
            if (w_timeout)
                r_resp_rdata <= '0;
            if (r_state == RD_CAPT) begin
                r_resp_rdata <= mm_rdata;
                r_resp_tag   <= mm_tag;
                assert (mm_tag == tag_of(r_addr));
            end
        end
    end

    assign resp_rdata = r_resp_rdata;
    assign resp_tag   = r_resp_tag;

endmodule

// File: tb/tb_mm_requester.sv
// Directed bench for mm_requester with a behavioural dual-port memory responder.
module tb_mm_requester;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_tag;
    logic        resp_err;
    logic        mm_read;
    logic        mm_write;
    logic [3:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic        mm_valid;
    logic [31:0] mm_rdata;
    logic [1:0]  mm_tag;

    int checks   = 0;
    int failures = 0;

    mm_requester dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_tag(resp_tag),
        .resp_err(resp_err),
        .mm_read(mm_read), .mm_write(mm_write), .mm_addr(mm_addr),
        .mm_wdata(mm_wdata), .mm_valid(mm_valid), .mm_rdata(mm_rdata),
        .mm_tag(mm_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: mm_valid appears after 'stall' cycles of mm_read,
    // read data/tag load on the edge closing the cycle after mm_valid.
    logic [31:0] mem [16];
    int          rd_cnt;
    int          stall;
    logic        ld;

    assign mm_valid = mm_read && (rd_cnt >= stall);

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[5]   = 32'h3;
        rd_cnt   = 0;
        ld       = 1'b0;
        mm_rdata = 32'h0;
        mm_tag   = 2'b00;
        forever begin
            @(posedge clk);
            if (mm_write) mem[mm_addr] <= mm_wdata;
            rd_cnt <= mm_read ? rd_cnt + 1 : 0;
            ld     <= mm_read && mm_valid;
            if (ld) begin
                mm_rdata <= mem[mm_addr];
                mm_tag   <= mm_addr[3:2];
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        int          stall;
        bit          noise;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_tag;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input vec_t v, input int idx);
        int n_lat = 0, n_wr = 0, n_rd = 0, n_both = 0;
        int addr_bad = 0, wdata_bad = 0, ready_bad = 0;
        int lim = v.we ? 1 : v.exp_lat - 2;
        @(negedge clk);
        stall     = v.stall;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        if (v.noise) begin
            req_we    = 1'b1;
            req_addr  = 4'h3;
            req_wdata = 32'h1111_1111;
        end else begin
            req_valid = 1'b0;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mm_write) n_wr++;
            if (mm_read) n_rd++;
            if (mm_write && mm_read) n_both++;
            if (mm_write && mm_wdata !== v.wdata) wdata_bad++;
            if (n <= lim && mm_addr !== v.addr) addr_bad++;
            if (req_ready) ready_bad++;
            if (resp_valid) begin
                n_lat = n;
                break;
            end
        end
        req_valid = 1'b0;
        check($sformatf("v%0d_latency", idx), 64'(n_lat), 64'(v.exp_lat));
        check($sformatf("v%0d_write_cycles", idx), 64'(n_wr), v.we ? 64'd1 : 64'd0);
        check($sformatf("v%0d_read_cycles", idx), 64'(n_rd), v.we ? 64'd0 : 64'(v.stall + 1));
        check($sformatf("v%0d_strobe_overlap", idx), 64'(n_both), 64'd0);
        check($sformatf("v%0d_wdata", idx), 64'(wdata_bad), 64'd0);
        check($sformatf("v%0d_addr_stable", idx), 64'(addr_bad), 64'd0);
        check($sformatf("v%0d_ready_busy", idx), 64'(ready_bad), 64'd0);
        check($sformatf("v%0d_rdata", idx), 64'(resp_rdata), 64'(v.exp_rdata));
        check($sformatf("v%0d_tag", idx), 64'(resp_tag), 64'(v.exp_tag));
        check($sformatf("v%0d_err", idx), 64'(resp_err), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_pulse_end", idx), 64'(resp_valid), 64'd0);
        check($sformatf("v%0d_ready_back", idx), 64'(req_ready), 64'd1);
        check($sformatf("v%0d_idle_addr", idx), 64'(mm_addr), 64'd0);
    endtask

    initial begin
        int n_resp, n_rd;
        //                we    addr   wdata         stall noise exp_rdata     tag    lat
        vecs[0] = '{1'b1, 4'h9, 32'hDEADBEEF, 0, 1'b0, 32'h0,        2'b10, 2};
        vecs[1] = '{1'b0, 4'h5, 32'h0,        0, 1'b0, 32'h3,        2'b01, 4};
        vecs[2] = '{1'b1, 4'hE, 32'h7,        0, 1'b0, 32'h3,        2'b11, 2};
        vecs[3] = '{1'b0, 4'hE, 32'h0,        0, 1'b1, 32'h7,        2'b11, 4};
        vecs[4] = '{1'b0, 4'h9, 32'h0,        0, 1'b0, 32'hDEADBEEF, 2'b10, 4};
        vecs[5] = '{1'b0, 4'h5, 32'h0,        3, 1'b1, 32'h3,        2'b01, 7};
        vecs[6] = '{1'b1, 4'h0, 32'hA5A5A5A5, 0, 1'b0, 32'h3,        2'b00, 2};
        vecs[7] = '{1'b0, 4'h0, 32'h0,        1, 1'b0, 32'hA5A5A5A5, 2'b00, 5};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 4'h0;
        req_wdata = 32'h0;
        stall     = 0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_strobes", 64'({resp_valid, resp_err, mm_read, mm_write}), 64'd0);
        check("reset_bus", 64'({mm_addr, mm_wdata, resp_rdata, resp_tag}), 64'd0);
        rst_n = 1'b1;

        // Reset while parked in RD_REQ: abort, no late response.
        @(negedge clk);
        stall     = 20;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'h5;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("midread_strobe", 64'(mm_read), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", 64'({mm_read, mm_write, resp_valid}), 64'd0);
        check("abort_bus", 64'({mm_addr, mm_wdata}), 64'd0);
        check("abort_ready", 64'(req_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        n_resp = 0;
        n_rd   = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
            if (mm_read) n_rd++;
        end
        check("abort_no_resp", 64'(n_resp), 64'd0);
        check("abort_no_read", 64'(n_rd), 64'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
        check("noise_not_written", 64'(mem[3]), 64'd0);

        // Responder that never answers.
        @(negedge clk);
        stall     = 1000;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'hB;
        @(posedge clk);
        #1 req_valid = 1'b0;
`ifdef MM_TIMEOUT_EN
        n_resp = 0;
        n_rd   = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (mm_read) n_rd++;
            if (resp_valid) begin
                n_resp = n;
                break;
            end
        end
        check("timeout_latency", 64'(n_resp), 64'd16);
        check("timeout_read_cycles", 64'(n_rd), 64'd15);
        check("timeout_err", 64'(resp_err), 64'd1);
        check("timeout_rdata", 64'(resp_rdata), 64'd0);
        check("timeout_tag", 64'(resp_tag), 64'(2'b10));
        @(negedge clk);
        check("timeout_ready_back", 64'(req_ready), 64'd1);
`else
        n_resp = 0;
        n_rd   = 0;
        repeat (30) begin
            @(negedge clk);
            if (mm_read) n_rd++;
            if (resp_valid) n_resp++;
        end
        check("hang_read_held", 64'(n_rd), 64'd30);
        check("hang_no_resp", 64'(n_resp), 64'd0);
        check("hang_err", 64'(resp_err), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("hang_recover_ready", 64'(req_ready), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
